// File: rtl/intg_pkg.sv
// Shared types and widths for the window-integrator result path.
package intg_pkg;

    localparam int unsigned SUM_W     = 13;
    localparam int unsigned AVG_SHIFT = 2;

    typedef struct packed {
        logic                         over;
        logic [SUM_W-AVG_SHIFT-1:0]   avg;
        logic [SUM_W-1:0]             sum;
    } result_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

endpackage

// File: rtl/intg_result_fifo.sv
// Generic register-array FIFO with exact count; head is read straight from
// storage so a pushed word is visible the cycle after its push edge.
module intg_result_fifo
    import intg_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output occ_t                     occ,
    output logic                     push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == FULL_CNT)
            occ = OCC_FULL;
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop_ok  = pop && (occ != OCC_EMPTY);
    assign push_ok = push && ((occ != OCC_FULL) || pop_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (!push_ok && pop_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !reset)
            mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/intg_result_buffer.sv
// Result buffer behind the window integrator: average, threshold flag, FIFO.
// Optional min/max statistics ports are enabled by defining INTG_RESULT_STATS_EN.
module intg_result_buffer #(
    parameter int unsigned SUM_W     = 13,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AVG_SHIFT = 2,
    parameter int unsigned THRESH    = 200
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SUM_W-1:0]            sum_in,
    input  logic                        sum_valid,
    output logic [SUM_W-1:0]            out_sum,
    output logic [SUM_W-AVG_SHIFT-1:0]  out_avg,
    output logic                        out_over,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow
`ifdef INTG_RESULT_STATS_EN
    ,
    output logic [SUM_W-1:0]            max_sum,
    output logic [SUM_W-1:0]            min_sum
`endif
);

    import intg_pkg::*;

    localparam int unsigned AVG_W = SUM_W - AVG_SHIFT;
    localparam logic [AVG_W-1:0] THRESH_V = AVG_W'(THRESH);

    logic [AVG_W-1:0] avg;
    result_t          entry_in;
    result_t          head;
    occ_t             occ;
    logic             pop_req;
    logic             push_ok;

    always_comb begin
        avg            = AVG_W'(sum_in >> AVG_SHIFT);
        entry_in.sum   = sum_in;
        entry_in.avg   = avg;
        entry_in.over  = (avg >= THRESH_V);
    end

    intg_result_fifo #(
        .W     ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (sum_valid),
        .pop     (pop_req),
        .wr_data (entry_in),
        .head    (head),
        .count   (count),
        .occ     (occ),
        .push_ok (push_ok)
    );

    assign out_valid = (occ != OCC_EMPTY);
    assign pop_req   = out_valid && out_ready;

    // Storage is not cleared by reset, so an empty head reads as zero.
    assign out_sum  = out_valid ? head.sum  : '0;
    assign out_avg  = out_valid ? head.avg  : '0;
    assign out_over = out_valid ? head.over : 1'b0;

    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (sum_valid && (occ == OCC_FULL) && !pop_req)
            overflow <= 1'b1;
    end

`ifdef INTG_RESULT_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            max_sum <= '0;
            min_sum <= '1;
        end else if (push_ok) begin
            if (sum_in > max_sum)
                max_sum <= sum_in;
            if (sum_in < min_sum)
                min_sum <= sum_in;
        end
    end
`else
    logic unused_push_ok;
    assign unused_push_ok = push_ok;
`endif

endmodule

// File: tb/tb_intg_result_buffer.sv
// Scoreboard bench for intg_result_buffer; expected entries are queued at push
// time and checked by a monitor whenever the DUT hands over its head entry.
module tb_intg_result_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [12:0] sum_in;
    logic        sum_valid;
    logic [12:0] out_sum;
    logic [10:0] out_avg;
    logic        out_over;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
`ifdef INTG_RESULT_STATS_EN
    logic [12:0] max_sum;
    logic [12:0] min_sum;
`endif

    typedef struct {
        int unsigned sum;
        int unsigned avg;
        int unsigned over;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    intg_result_buffer #(
        .SUM_W     (13),
        .DEPTH     (4),
        .AVG_SHIFT (2),
        .THRESH    (200)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_over  (out_over),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
`ifdef INTG_RESULT_STATS_EN
        ,
        .max_sum   (max_sum),
        .min_sum   (min_sum)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total_cnt++;
        if (act == req)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one window for one edge; accepted windows get their hand-computed result queued.
    task automatic push_win(input int unsigned s, input bit accept,
                            input int unsigned a, input int unsigned o);
        exp_t e;
        sum_in    = 13'(s);
        sum_valid = 1'b1;
        if (accept) begin
            e.sum = s; e.avg = a; e.over = o;
            exp_q.push_back(e);
        end
        tick();
        sum_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL head_unexpected: got sum %0d, expected no entry", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("head_sum",  out_sum,  e.sum);
                check("head_avg",  out_avg,  e.avg);
                check("head_over", out_over, e.over);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        sum_in    = '0;
        sum_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();

        @(negedge clock);
        check("rst_valid",    out_valid, 0);
        check("rst_count",    count,     0);
        check("rst_overflow", overflow,  0);
        check("rst_sum",      out_sum,   0);
        check("rst_avg",      out_avg,   0);
        check("rst_over",     out_over,  0);
        tick();

        // Single window, consumer ready
        out_ready = 1'b1;
        push_win(700, 1, 175, 0);
        @(negedge clock);
        check("t1_valid", out_valid, 1);
        check("t1_count", count, 1);
        tick();
        @(negedge clock);
        check("t1_count_after_pop", count, 0);
        tick();

        // Threshold boundary around an average of 200
        push_win(1000, 1, 250, 1);
        push_win(800,  1, 200, 1);
        push_win(796,  1, 199, 0);
        tick();
        @(negedge clock);
        check("t2_count", count, 0);
        tick();

        // Overfill with consumer stalled, then drain
        out_ready = 1'b0;
        push_win(100, 1, 25, 0);
        push_win(200, 1, 50, 0);
        push_win(300, 1, 75, 0);
        push_win(400, 1, 100, 0);
        push_win(500, 0, 125, 0);
        @(negedge clock);
        check("t3_count_full", count, 4);
        check("t3_overflow",   overflow, 1);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        @(negedge clock);
        check("t3_count_drained", count, 0);
        check("t3_valid_drained", out_valid, 0);
        check("t3_overflow_sticky", overflow, 1);
        tick();

        // Full with simultaneous push and pop
        do_reset();
        push_win(100, 1, 25, 0);
        push_win(200, 1, 50, 0);
        push_win(300, 1, 75, 0);
        push_win(400, 1, 100, 0);
        @(negedge clock);
        check("t4_count_full", count, 4);
        tick();
        out_ready = 1'b1;
        push_win(600, 1, 150, 0);
        @(negedge clock);
        check("t4_count_hold", count, 4);
        check("t4_no_overflow", overflow, 0);
        tick();
        out_ready = 1'b0;

        // Stall with head 300: one accepted and one dropped push meanwhile
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                exp_t e;
                e.sum = 700; e.avg = 175; e.over = 0;
                exp_q.push_back(e);
                sum_in = 13'd700; sum_valid = 1'b1;
            end else if (i == 1) begin
                sum_in = 13'd900; sum_valid = 1'b1;
            end else begin
                sum_valid = 1'b0;
            end
            @(negedge clock);
            check("t5_stall_valid", out_valid, 1);
            check("t5_stall_sum",   out_sum, 300);
            check("t5_stall_avg",   out_avg, 75);
            check("t5_stall_over",  out_over, 0);
            tick();
        end
        sum_valid = 1'b0;
        @(negedge clock);
        check("t5_count", count, 4);
        check("t5_overflow", overflow, 1);
        tick();

        // Reset mid-queue with a window offered on the reset edge
        sum_in    = 13'd999;
        sum_valid = 1'b1;
        do_reset();
        sum_valid = 1'b0;
        @(negedge clock);
        check("t6_count", count, 0);
        check("t6_valid", out_valid, 0);
        check("t6_overflow", overflow, 0);
        check("t6_sum", out_sum, 0);
        tick();

        // Operation resumes after reset
        out_ready = 1'b1;
        push_win(50, 1, 12, 0);
        @(negedge clock);
        check("t7_count", count, 1);
        tick();
        @(negedge clock);
        check("t7_count_after_pop", count, 0);
        tick();

`ifdef INTG_RESULT_STATS_EN
        do_reset();
        @(negedge clock);
        check("stats_rst_max", max_sum, 0);
        check("stats_rst_min", min_sum, 8191);
        tick();
        push_win(700,  1, 175, 0);
        push_win(150,  1, 37,  0);
        push_win(1000, 1, 250, 1);
        tick();
        @(negedge clock);
        check("stats_max", max_sum, 1000);
        check("stats_min", min_sum, 150);
        tick();
`endif

        out_ready = 1'b0;
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/intg_result_buffer.md
Name: intg_result_buffer

Overview:
- Downstream stage of the 25·x window integrator.
- Captures each completed 13-bit window sum when the integrator strobes end-of-window, and derives a per-sample average and a threshold flag.
- Queues results in a small FIFO and presents them to the consumer on a valid/ready handshake.
- Decouples the integrator's fixed window cadence from a consumer that may stall.

Parameters:
- SUM_W, 13, width of incoming window sum
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AVG_SHIFT, 2, right shift applied to the sum to form the average (window of 2^AVG_SHIFT samples)
- THRESH, 200, average at or above this value sets the over flag

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- sum_in  in  SUM_W  window sum from integrator
- sum_valid  in  1  one-cycle strobe: sum_in is a completed window
- out_sum  out  SUM_W  head-entry raw sum
- out_avg  out  SUM_W-AVG_SHIFT  head-entry average
- out_over  out  1  head-entry flag: out_avg >= THRESH
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head this cycle
- count  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky: a window was dropped

Behaviour:
- Reset, synchronous: clears pointers, count=0, out_valid=0, overflow=0. out_sum, out_avg and out_over all read 0.
- Push: on a clock edge with sum_valid=1, the entry {over, avg, sum} is written.
  - avg = sum_in >> AVG_SHIFT, truncating.
  - over = (avg >= THRESH), compared unsigned.
- Pop: on a clock edge with out_valid & out_ready.
- Latency: the entry is visible on the outputs the cycle after its push edge (first-word fall-through on a registered head). out_valid rises on that same cycle.
- Outputs are driven from the head entry. They are held stable while out_valid=1 and out_ready=0.
- Full (count==DEPTH), push without pop: entry dropped, overflow←1 (sticky until reset), contents unchanged.
- Full with simultaneous push and pop: both occur, count stays DEPTH, no overflow.
- Empty with simultaneous push and pop: the pop is ignored (out_valid=0). The push proceeds and count becomes 1.
- Pointers wrap modulo DEPTH. Count is always exact: 0..DEPTH.
- Reset asserted mid-operation: all queued entries are discarded that edge. sum_valid on the reset edge is ignored.
- Occupancy state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions:
  - +1 on push-only.
  - −1 on pop-only.
  - Hold on both or neither.
  - FULL+push-only → FULL with overflow.

Optional Feature:
- INTG_RESULT_STATS_EN.
- When defined, adds outputs max_sum and min_sum (SUM_W each), computed over all accepted pushes since reset.
  - Reset values: max_sum=0, min_sum=all-ones.
  - Both update on the push edge. Dropped windows are not counted.
- When undefined, these ports and their registers do not exist, and the block is otherwise identical.

Decomposition:
- Shared package intg_pkg holds:
  - SUM_W and AVG_SHIFT constants.
  - A result entry struct typedef {over, avg, sum}.
  - An occupancy enum {OCC_EMPTY, OCC_PARTIAL, OCC_FULL}.
- One natural sub-module, intg_result_fifo: a generic storage array with pointers and count.
- The top level adds average/threshold computation, overflow and optional stats.

Test Plan:
- Reset, then push sum_in=700 (x=10,5,12,1 window) with out_ready=1 → next cycle out_valid=1, out_sum=700, out_avg=175, out_over=0, count=1. Pop → count=0.
- Push 1000 → out_avg=250, out_over=1. Push 800 → out_avg=200, out_over=1 (equality boundary). Push 796 → out_avg=199, out_over=0.
- out_ready=0, push 5 windows (100,200,300,400,500) → count=4, overflow=1. Drain → 100,200,300,400 in order, and 500 is absent.
- Full, with push 600 and pop in the same cycle → count stays 4, overflow unchanged. Drain order is 200,300,400,600.
- Stall: out_ready=0 for 3 cycles with head=300 → outputs are stable. Assert reset mid-queue → count=0, out_valid=0, overflow=0 on the next cycle.
- With INTG_RESULT_STATS_EN defined, push 700,150,1000 → max_sum=1000, min_sum=150.
